// File: rtl/add_sub_result_fifo.sv
// Result FIFO behind the 4-bit adder/subtractor: stores {op, Z/N/C/V, sum} per result.
// Optional statistics counters are enabled with `define ADD_SUB_RESULT_STATS_EN.
module add_sub_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum,
    input  logic             carry,
    input  logic             CTR,
    input  logic             a_msb,
    input  logic             b_msb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [3:0]       out_flags,
    output logic             out_op,
    output logic [AW:0]      count,
    output logic             drop_err
`ifdef ADD_SUB_RESULT_STATS_EN
    ,
    output logic [15:0]      op_cnt,
    output logic [15:0]      ovf_cnt
`endif
);

    typedef struct packed {
        logic             op;
        logic [3:0]       flags;
        logic [WIDTH-1:0] sum;
    } entry_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    entry_t            mem_q [DEPTH];
    entry_t            mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              drop_err_q, drop_err_d;

    logic              full, empty;
    logic              push, pop;
    logic              z_flag, n_flag, c_flag, v_flag;
    entry_t            wr_entry;
    entry_t            head;

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign push  = in_valid && !full;
    assign pop   = out_ready && !empty;

    // Overflow: operands effectively share a sign (b inverted for subtract) and result sign differs from a.
    always_comb begin
        z_flag = (sum == '0);
        n_flag = sum[WIDTH-1];
        c_flag = carry;
        if (CTR) begin
            v_flag = (a_msb != b_msb) && (sum[WIDTH-1] != a_msb);
        end else begin
            v_flag = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
        end
        wr_entry.op    = CTR;
        wr_entry.flags = {z_flag, n_flag, c_flag, v_flag};
        wr_entry.sum   = sum;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_err_d = drop_err_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (in_valid && full) begin
            drop_err_d = 1'b1;
        end
    end

    // Storage carries no reset; emptiness is tracked solely by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_err_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_err_q <= drop_err_d;
        end
    end

    always_comb begin
        head = mem_q[rd_ptr_q];
        if (empty) begin
            head = '0;
        end
    end

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_sum   = head.sum;
    assign out_flags = head.flags;
    assign out_op    = head.op;
    assign count     = count_q;
    assign drop_err  = drop_err_q;

`ifdef ADD_SUB_RESULT_STATS_EN
    logic [15:0] op_cnt_q, op_cnt_d;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        op_cnt_d  = op_cnt_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push && (op_cnt_q != '1)) begin
            op_cnt_d = op_cnt_q + 16'd1;
        end
        if (push && v_flag && (ovf_cnt_q != '1)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q  <= '0;
            ovf_cnt_q <= '0;
        end else begin
            op_cnt_q  <= op_cnt_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign op_cnt  = op_cnt_q;
    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_add_sub_result_fifo.sv
// Self-checking bench for add_sub_result_fifo: directed scenarios plus randomized traffic
// checked against a queue model that derives flags from signed/unsigned operand arithmetic.
module tb_add_sub_result_fifo;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             CTR;
    logic             a_msb;
    logic             b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [3:0]       out_flags;
    logic             out_op;
    logic [AW:0]      count;
    logic             drop_err;
`ifdef ADD_SUB_RESULT_STATS_EN
    logic [15:0]      op_cnt;
    logic [15:0]      ovf_cnt;
`endif

    add_sub_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .carry     (carry),
        .CTR       (CTR),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_flags (out_flags),
        .out_op    (out_op),
        .count     (count),
        .drop_err  (drop_err)
`ifdef ADD_SUB_RESULT_STATS_EN
        ,
        .op_cnt    (op_cnt),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sum;
        logic [3:0] flags;
        logic       op;
    } exp_t;

    exp_t mq[$];
    exp_t cur_exp;
    bit   m_drop;
    int   errors = 0;
    int   checks = 0;

    // Expected entry straight from the arithmetic: unsigned sum/carry, signed range for V.
    function automatic exp_t exp_of(input int a, input int b, input bit sub);
        exp_t e;
        int   u, sa, sb, r, s;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        r  = sub ? sa - sb : sa + sb;
        u  = sub ? a + (15 - b) + 1 : a + b;
        s  = u % 16;
        e.sum   = 4'(s);
        e.flags = {(s == 0), (s >= 8), (u >= 16), (r > 7 || r < -8)};
        e.op    = sub;
        return e;
    endfunction

    task automatic set_op(input int a, input int b, input bit sub);
        int u;
        u     = sub ? a + (15 - b) + 1 : a + b;
        sum   = 4'(u % 16);
        carry = (u >= 16);
        CTR   = sub;
        a_msb = (a >= 8);
        b_msb = (b >= 8);
        cur_exp = exp_of(a, b, sub);
    endtask

    task automatic set_rand_op();
        set_op($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    endtask

    // Advance one clock and update the model; leaves time at posedge + 1.
    task automatic tick();
        bit push, pop;
        push = in_valid && (mq.size() < DEPTH);
        pop  = out_ready && (mq.size() != 0);
        if (in_valid && !push) m_drop = 1'b1;
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(cur_exp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(0, 0, 1'b0);
        #3;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (drop_err !== 1'b0) begin errors++; $display("FAIL reset_drop_err got=%b exp=0", drop_err); end
        checks++; if ({out_sum, out_flags, out_op} !== 9'd0) begin errors++; $display("FAIL reset_head got=%h exp=0", {out_sum, out_flags, out_op}); end
        mq.delete(); m_drop = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_flags();
        out_ready = 1'b0;
        set_op(5, 3, 1'b0);
        in_valid = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got=%b exp=0", out_valid); end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        checks++; if (out_sum !== 4'b1000) begin errors++; $display("FAIL add_sum got=%b exp=1000", out_sum); end
        checks++; if (out_flags !== 4'b0101) begin errors++; $display("FAIL add_flags got=%b exp=0101", out_flags); end
        checks++; if (out_op !== 1'b0) begin errors++; $display("FAIL add_op got=%b exp=0", out_op); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        set_op(5, 5, 1'b1);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        checks++; if (out_sum !== 4'b0000) begin errors++; $display("FAIL sub_sum got=%b exp=0000", out_sum); end
        checks++; if (out_flags !== 4'b1010) begin errors++; $display("FAIL sub_flags got=%b exp=1010", out_flags); end
        checks++; if (out_op !== 1'b1) begin errors++; $display("FAIL sub_op got=%b exp=1", out_op); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flags_drain_count got=%0d exp=0", count); end
    endtask

    task automatic drain_check(input string tag);
        out_ready = 1'b1; in_valid = 1'b0;
        for (int i = 0; i < DEPTH + 1 && mq.size() != 0; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_sum !== mq[0].sum || out_flags !== mq[0].flags || out_op !== mq[0].op) begin
                errors++;
                $display("FAIL %s_head got=%b/%b/%b/%b exp=1/%b/%b/%b", tag, out_valid, out_sum, out_flags, out_op,
                         mq[0].sum, mq[0].flags, mq[0].op);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL %s_empty count=%0d valid=%b exp=0/0", tag, count, out_valid); end
    endtask

    task automatic test_fill_drop();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_rand_op();
            in_valid = 1'b1;
            checks++; if (in_ready !== (i < DEPTH)) begin errors++; $display("FAIL fill_in_ready[%0d] got=%b exp=%b", i, in_ready, (i < DEPTH)); end
            tick();
        end
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got=%0d exp=4", count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_ready got=%b exp=0", in_ready); end
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_err got=%b exp=1", drop_err); end
        drain_check("fill");
        checks++; if ({out_sum, out_flags, out_op} !== 9'd0) begin errors++; $display("FAIL empty_head got=%h exp=0", {out_sum, out_flags, out_op}); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
        checks++; if (drop_err !== 1'b1) begin errors++; $display("FAIL drop_sticky got=%b exp=1", drop_err); end
    endtask

    task automatic test_full_pop();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_rand_op(); in_valid = 1'b1; tick();
        end
        set_rand_op();
        in_valid = 1'b1; out_ready = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fullpop_ready got=%b exp=0", in_ready); end
        tick();
        out_ready = 1'b0;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL fullpop_count got=%0d exp=3", count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_ready_after got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpop_refill got=%0d exp=4", count); end
        drain_check("fullpop");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_rand_op(); in_valid = 1'b1; tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_rand_op();
            in_valid = 1'b1;
            checks++;
            if (out_sum !== mq[0].sum || out_flags !== mq[0].flags || out_op !== mq[0].op) begin
                errors++;
                $display("FAIL b2b_head[%0d] got=%b/%b/%b exp=%b/%b/%b", i, out_sum, out_flags, out_op, mq[0].sum, mq[0].flags, mq[0].op);
            end
            tick();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count[%0d] got=%0d exp=2", i, count); end
        end
        drain_check("b2b");
    endtask

    task automatic test_mid_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_rand_op(); in_valid = 1'b1; tick();
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++; if (out_valid !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL midreset valid=%b count=%0d exp=0/0", out_valid, count); end
        checks++; if (in_ready !== 1'b1 || drop_err !== 1'b0) begin errors++; $display("FAIL midreset ready=%b drop=%b exp=1/0", in_ready, drop_err); end
        mq.delete(); m_drop = 1'b0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            set_rand_op();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            checks++;
            if (out_valid !== (mq.size() != 0) || in_ready !== (mq.size() < DEPTH) ||
                count !== 3'(mq.size()) || drop_err !== m_drop) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] valid=%b ready=%b count=%0d drop=%b exp=%b/%b/%0d/%b", i,
                         out_valid, in_ready, count, drop_err, (mq.size() != 0), (mq.size() < DEPTH), mq.size(), m_drop);
            end
            if (mq.size() != 0) begin
                checks++;
                if (out_sum !== mq[0].sum || out_flags !== mq[0].flags || out_op !== mq[0].op) begin
                    errors++;
                    $display("FAIL rand_head[%0d] got=%b/%b/%b exp=%b/%b/%b", i, out_sum, out_flags, out_op, mq[0].sum, mq[0].flags, mq[0].op);
                end
            end
            tick();
        end
        drain_check("rand");
    endtask

    initial begin
        test_reset();
        test_flags();
        test_fill_drop();
        test_full_pop();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
